// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan controller.
//   - fnd_state_t : scan FSM states (IDLE / BLANK / SHOW)
//   - SEG_OFF     : all segments and dp dark (active-low)
//   - SEG_TABLE   : hex digit -> active-low segment pattern, dp bit off
package fnd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } fnd_state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Common-anode patterns, bit 7 = dp (kept high = off), [6:0] = g..a.
    localparam logic [7:0] SEG_TABLE [0:15] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/fnd_hex_decoder.sv
// Combinational hex-to-7-segment decoder for a common-anode display.
// Ports:
//   i_nibble : hex value to show
//   i_dp     : 1 = light the decimal point
//   i_blank  : 1 = dark all digit segments (dp still follows i_dp)
//   o_seg    : active-low segments, [7]=dp, [6:0]=g..a
module fnd_hex_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    logic [7:0] w_pattern;

    always_comb begin
        w_pattern = SEG_TABLE[i_nibble];
        o_seg[7]   = ~i_dp;
        o_seg[6:0] = i_blank ? 7'h7F : w_pattern[6:0];
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit FND.
// Each digit slot is CLK_DIV cycles: DEAD_CYCLES with every digit off
// (suppresses ghosting while the anode driver switches), then the digit.
// The displayed value is sampled into shadow registers only when a frame
// starts, so a frame never mixes old and new digits.
// Ports:
//   i_clk, i_reset    : clock, asynchronous active-high reset
//   i_enable          : display on/off; low aborts immediately
//   i_value           : hex nibbles, nibble k -> digit k (digit 0 rightmost)
//   i_dp              : decimal point per digit, 1 = lit
//   i_blank_lz        : 1 = blank leading zeros
//   o_digit_sel       : active-low digit enables (one-cold or all ones)
//   o_seg             : active-low segments, [7]=dp, [6:0]=g..a
//   o_digit_idx       : current slot index (0 while idle)
//   o_frame_done      : one-cycle pulse after the frame wraps
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int CLK_DIV     = 100000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic                  i_blank_lz,
    output logic [DIGITS-1:0]     o_digit_sel,
    output logic [7:0]            o_seg,
    output logic [2:0]            o_digit_idx,
    output logic                  o_frame_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DIGITS - 1);

    fnd_state_t            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [2:0]            r_idx;
    logic [4*DIGITS-1:0]   r_value;
    logic [DIGITS-1:0]     r_dp;
    logic                  r_lz;
    logic [DIGITS-1:0]     r_digit_sel;
    logic [7:0]            r_seg;
    logic [2:0]            r_digit_idx;
    logic                  r_frame_done;

    fnd_state_t            w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [2:0]            w_idx_nxt;
    logic                  w_latch;
    logic                  w_wrap;

    logic [3:0]            w_nibble;
    logic                  w_dp_bit;
    logic                  w_blank;
    logic [DIGITS:0]       w_zero_from;
    logic [7:0]            w_dec_seg;

    // Next-state logic. The counter runs 0..CLK_DIV-1 across one slot;
    // the BLANK->SHOW boundary sits at DEAD_CYCLES inside that range.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_latch     = 1'b0;
        w_wrap      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
                w_idx_nxt   = 3'd0;
                w_latch     = 1'b1;
            end
            ST_BLANK: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == DEAD_LAST) begin
                    w_state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (r_cnt == SLOT_LAST) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    if (r_idx == IDX_LAST) begin
                        w_idx_nxt = 3'd0;
                        w_wrap    = 1'b1;
                        w_latch   = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = 3'd0;
            end
        endcase
        // Disable wins from any state and aborts the slot without a wrap.
        if (!i_enable) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = 3'd0;
            w_latch     = 1'b0;
            w_wrap      = 1'b0;
        end
    end

    // Digit data for the current index. The index only changes on entry to
    // BLANK, so whenever the next state is SHOW r_idx is already the digit
    // that will be shown.
    always_comb begin
        w_zero_from[DIGITS] = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_zero_from[k] = w_zero_from[k+1] && (r_value[4*k +: 4] == 4'h0);
        end
        w_nibble = 4'h0;
        w_dp_bit = 1'b0;
        w_blank  = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == 3'(k)) begin
                w_nibble = r_value[4*k +: 4];
                w_dp_bit = r_dp[k];
                // Digit 0 always shows, even for an all-zero value.
                w_blank  = r_lz && (k != 0) && w_zero_from[k];
            end
        end
    end

    fnd_hex_decoder u_dec (
        .i_nibble (w_nibble),
        .i_dp     (w_dp_bit),
        .i_blank  (w_blank),
        .o_seg    (w_dec_seg)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= 3'd0;
            r_value      <= '0;
            r_dp         <= '0;
            r_lz         <= 1'b0;
            r_digit_sel  <= '1;
            r_seg        <= SEG_OFF;
            r_digit_idx  <= 3'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_digit_idx  <= w_idx_nxt;
            r_frame_done <= w_wrap;
            if (w_latch) begin
                r_value <= i_value;
                r_dp    <= i_dp;
                r_lz    <= i_blank_lz;
            end
            // Outputs are registered from the next state so they line up
            // with the state register.
            if (w_state_nxt == ST_SHOW) begin
                r_digit_sel <= ~(DIGITS'(1) << w_idx_nxt);
                r_seg       <= w_dec_seg;
            end else begin
                r_digit_sel <= '1;
                r_seg       <= SEG_OFF;
            end
        end
    end

    assign o_digit_sel  = r_digit_sel;
    assign o_seg        = r_seg;
    assign o_digit_idx  = r_digit_idx;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: two instances (slot 8 and slot 3 cycles) run
// from shared inputs and are checked every cycle against a time-based
// model: cycles since enable -> slot, digit, position within slot.
module tb_fnd_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DEAD   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] val;
    logic [3:0]  dp;
    logic        lz;

    logic [3:0]  sel_a, sel_b;
    logic [7:0]  seg_a, seg_b;
    logic [2:0]  idx_a, idx_b;
    logic        fd_a, fd_b;

    int compared   = 0;
    int mismatched = 0;

    // model state, one entry per instance
    int          divs [2] = '{8, 3};
    bit          act  [2];
    int          t    [2];
    logic [15:0] lval [2];
    logic [3:0]  ldp  [2];
    bit          llz  [2];

    logic [7:0] seg_ref [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    always #5 clk = ~clk;

    fnd_scan_ctrl #(.DIGITS(DIGITS), .CLK_DIV(8), .DEAD_CYCLES(DEAD)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_value(val), .i_dp(dp),
        .i_blank_lz(lz), .o_digit_sel(sel_a), .o_seg(seg_a),
        .o_digit_idx(idx_a), .o_frame_done(fd_a)
    );

    fnd_scan_ctrl #(.DIGITS(DIGITS), .CLK_DIV(3), .DEAD_CYCLES(DEAD)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_value(val), .i_dp(dp),
        .i_blank_lz(lz), .o_digit_sel(sel_b), .o_seg(seg_b),
        .o_digit_idx(idx_b), .o_frame_done(fd_b)
    );

    function automatic logic [7:0] ref_seg(logic [15:0] v, logic [3:0] d, bit z, int k);
        logic [7:0] s;
        int nib;
        bit blank;
        nib   = int'((v >> (4 * k)) & 16'hF);
        blank = z && (k != 0) && ((v >> (4 * k)) == 16'h0);
        s = blank ? 8'hFF : seg_ref[nib];
        if (d[k]) s[7] = 1'b0;
        return s;
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        for (int n = 0; n < 2; n++) begin
            if (rst || !en) begin
                act[n] = 1'b0;
            end else if (!act[n]) begin
                act[n] = 1'b1;
                t[n] = 0;
                lval[n] = val; ldp[n] = dp; llz[n] = lz;
            end else begin
                t[n]++;
                if (t[n] % (divs[n] * DIGITS) == 0) begin
                    lval[n] = val; ldp[n] = dp; llz[n] = lz;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [7:0] e_sel, e_seg, e_idx, e_fd;
        int pos, dig;
        for (int n = 0; n < 2; n++) begin
            e_sel = 8'h0F; e_seg = 8'hFF; e_idx = 8'h00; e_fd = 8'h00;
            if (act[n]) begin
                pos   = t[n] % divs[n];
                dig   = (t[n] / divs[n]) % DIGITS;
                e_idx = 8'(dig);
                e_fd  = (t[n] > 0 && t[n] % (divs[n] * DIGITS) == 0) ? 8'h01 : 8'h00;
                if (pos >= DEAD) begin
                    e_sel = 8'h0F & ~(8'h01 << dig);
                    e_seg = ref_seg(lval[n], ldp[n], llz[n], dig);
                end
            end
            if (n == 0) begin
                chk($sformatf("a_sel t=%0d", t[0]), {4'h0, sel_a}, e_sel);
                chk($sformatf("a_seg t=%0d", t[0]), seg_a, e_seg);
                chk($sformatf("a_idx t=%0d", t[0]), {5'h0, idx_a}, e_idx);
                chk($sformatf("a_fd t=%0d", t[0]), {7'h0, fd_a}, e_fd);
            end else begin
                chk($sformatf("b_sel t=%0d", t[1]), {4'h0, sel_b}, e_sel);
                chk($sformatf("b_seg t=%0d", t[1]), seg_b, e_seg);
                chk($sformatf("b_idx t=%0d", t[1]), {5'h0, idx_b}, e_idx);
                chk($sformatf("b_fd t=%0d", t[1]), {7'h0, fd_b}, e_fd);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; val = 16'h0; dp = 4'h0; lz = 1'b0;
        for (int n = 0; n < 2; n++) begin
            act[n] = 1'b0; t[n] = 0; lval[n] = '0; ldp[n] = '0; llz[n] = 1'b0;
        end
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();

        // basic scan of 1234
        val = 16'h1234; en = 1'b1;
        repeat (3) step();
        chk("first_show_seg", seg_a, 8'h99);
        chk("first_show_sel", {4'h0, sel_a}, 8'h0E);
        repeat (67) step();

        // asynchronous reset between edges, then hold while disabled
        #2 rst = 1'b1;
        #1;
        for (int n = 0; n < 2; n++) act[n] = 1'b0;
        check_all();
        repeat (2) step();
        en = 1'b0;
        step();
        rst = 1'b0;
        repeat (4) step();

        // leading-zero blanking
        lz = 1'b1; val = 16'h0050; en = 1'b1;
        repeat (34) step();
        val = 16'h0000;
        repeat (32) step();
        dp = 4'b0100;
        repeat (40) step();

        // no tearing: change value during digit 1
        en = 1'b0; step();
        lz = 1'b0; dp = 4'h0; val = 16'h1234; en = 1'b1;
        repeat (12) step();
        val = 16'hABCD;
        repeat (60) step();

        // abort in SHOW of digit 2, then restart
        en = 1'b0; step();
        en = 1'b1;
        repeat (21) step();
        en = 1'b0; step();
        en = 1'b1;
        repeat (12) step();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) val = 16'($urandom);
            if ($urandom_range(0, 39) == 0) dp = 4'($urandom);
            if ($urandom_range(0, 39) == 0) lz = 1'($urandom);
            if ($urandom_range(0, 15) == 0) val[15:8] = 8'h00;
            if (en && $urandom_range(0, 119) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 2) == 0) en = 1'b1;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
